// File: rtl/vscale_hasti_arbiter_pkg.sv
// HASTI widths, response codes and data-phase owner encoding shared by the
// two-master HASTI arbiter and its starvation counter.
package vscale_hasti_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH = 32;
  localparam int HASTI_BUS_WIDTH  = 32;
  localparam int HASTI_SIZE_WIDTH = 3;
  localparam int HASTI_RESP_WIDTH = 1;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY = 1'b0;

  typedef enum logic [1:0] {
    DP_NONE = 2'd0,
    DP_P0   = 2'd1,
    DP_P1   = 2'd2
  } dp_owner_t;

  function automatic logic is_req(input logic read, input logic write);
    return read | write;
  endfunction

endpackage

// File: rtl/vscale_hasti_arbiter_if.sv
// Simplified HASTI bus bundle: master drives the address phase and wdata,
// slave returns rdata/ready/resp.
interface vscale_hasti_arbiter_if;
  import vscale_hasti_arbiter_pkg::*;

  logic [HASTI_ADDR_WIDTH-1:0] addr;
  logic                        read;
  logic                        write;
  logic [HASTI_SIZE_WIDTH-1:0] size;
  logic [HASTI_BUS_WIDTH-1:0]  wdata;
  logic [HASTI_BUS_WIDTH-1:0]  rdata;
  logic                        ready;
  logic [HASTI_RESP_WIDTH-1:0] resp;

  modport master (output addr, read, write, size, wdata, input rdata, ready, resp);
  modport slave  (input addr, read, write, size, wdata, output rdata, ready, resp);
endinterface

// File: rtl/vscale_arb_starve_ctr.sv
// Counts consecutive arbitration points lost by p1 and raises force_p1 once
// the streak reaches MAX_WAIT. Only built with VSCALE_ARB_STARVE_GUARD_EN.
module vscale_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_point,
  input  logic p1_req,
  input  logic p1_grant,
  input  logic accept,
  output logic force_p1
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_q;
  logic [3:0] wait_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!p1_req || (p1_grant && accept)) begin
      wait_d = '0;
    end else if (arb_point && !p1_grant && (wait_q != WAIT_LIMIT)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  assign force_p1 = (wait_q == WAIT_LIMIT);

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (p0 = dmem, p1 = imem) to one-slave HASTI arbiter, fixed priority
// p0 > p1, zero added latency. Define VSCALE_ARB_STARVE_GUARD_EN to add the p1 starvation guard.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  vscale_hasti_arbiter_if.slave         p0,
  vscale_hasti_arbiter_if.slave         p1,
  vscale_hasti_arbiter_if.master        s
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_max_wait_range
    $error("vscale_hasti_arbiter: MAX_WAIT must be within 1..15");
  end

  dp_owner_t dp_owner_q;
  dp_owner_t dp_owner_d;
  dp_owner_t owner;
  logic      p0_req;
  logic      p1_req;
  logic      arb_point;
  logic      accept;
  logic      grant_p0;
  logic      grant_p1;
  logic      force_p1;

`ifdef VSCALE_ARB_STARVE_GUARD_EN
  vscale_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .arb_point (arb_point),
    .p1_req    (p1_req),
    .p1_grant  (grant_p1),
    .accept    (accept),
    .force_p1  (force_p1)
  );
`else
  assign force_p1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_owner_q <= DP_NONE;
    end else begin
      dp_owner_q <= dp_owner_d;
    end
  end

  always_comb begin
    p0_req = is_req(p0.read, p0.write);
    p1_req = is_req(p1.read, p1.write);

    // While reset is high the in-flight data phase is already treated as gone.
    owner     = reset ? DP_NONE : dp_owner_q;
    arb_point = !reset && ((owner == DP_NONE) || s.ready);
    grant_p1  = arb_point && p1_req && (!p0_req || force_p1);
    grant_p0  = arb_point && p0_req && !grant_p1;
    accept    = arb_point && s.ready;

    dp_owner_d = dp_owner_q;
    if (accept) begin
      dp_owner_d = grant_p0 ? DP_P0 : (grant_p1 ? DP_P1 : DP_NONE);
    end

    s.addr  = grant_p1 ? p1.addr : p0.addr;
    s.size  = grant_p1 ? p1.size : p0.size;
    s.read  = (grant_p0 && p0.read)  || (grant_p1 && p1.read);
    s.write = (grant_p0 && p0.write) || (grant_p1 && p1.write);
    s.wdata = (owner == DP_P1) ? p1.wdata : p0.wdata;

    p0.rdata = (owner == DP_P0) ? s.rdata : '0;
    p1.rdata = (owner == DP_P1) ? s.rdata : '0;
    p0.resp  = (owner == DP_P0) ? s.resp  : HASTI_RESP_OKAY;
    p1.resp  = (owner == DP_P1) ? s.resp  : HASTI_RESP_OKAY;

    // Completing its own data phase takes precedence over a master's new request.
    p0.ready = reset || ((owner == DP_P0) ? s.ready : (!p0_req || (grant_p0 && s.ready)));
    p1.ready = reset || ((owner == DP_P1) ? s.ready : (!p1_req || (grant_p1 && s.ready)));
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Self-checking bench for vscale_hasti_arbiter: directed vector table, starvation
// sequence, then randomized traffic against a transaction-level reference model.
module tb_vscale_hasti_arbiter;
  import vscale_hasti_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;
`ifdef VSCALE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [31:0] W0 = 32'h1234_5678;
  localparam logic [31:0] W1 = 32'hCAFE_F00D;
  localparam int NVEC  = 12;
  localparam int NRAND = 800;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vscale_hasti_arbiter_if p0_bus ();
  vscale_hasti_arbiter_if p1_bus ();
  vscale_hasti_arbiter_if s_bus ();

  vscale_hasti_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .p0    (p0_bus),
    .p1    (p1_bus),
    .s     (s_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        p0_rd, p0_wr;
    logic [31:0] p0_a;
    logic        p1_rd;
    logic [31:0] p1_a;
    logic        sr;
    logic [31:0] srd;
    logic        e_sread, e_swrite;
    logic [31:0] e_saddr, e_swdata;
    logic        e_r0, e_r1;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vecs [NVEC];

  // Reference-model state for the random phase.
  int m_owner;   // 0 none, 1 p0, 2 p1
  int m_wait;    // consecutive arbitration points lost by p1
  bit p0_pend, p1_pend, p0_isw, p1_isw;
  logic [31:0] p0_a, p1_a, p0_wd, p1_wd, srd;
  logic [2:0]  p0_sz, p1_sz;
  logic        sr, sresp;

  task automatic idle_inputs();
    p0_bus.read = 1'b0; p0_bus.write = 1'b0; p0_bus.addr = '0; p0_bus.size = 3'd2; p0_bus.wdata = W0;
    p1_bus.read = 1'b0; p1_bus.write = 1'b0; p1_bus.addr = '0; p1_bus.size = 3'd2; p1_bus.wdata = W1;
    s_bus.ready = 1'b1; s_bus.rdata = '0; s_bus.resp = HASTI_RESP_OKAY;
  endtask

  initial begin
    idle_inputs();

    // rst, p0 rd/wr/addr, p1 rd/addr, s_ready, s_rdata | s_read, s_write, s_addr, s_wdata, rdy0, rdy1, rdata0, rdata1
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 32'h200, 1'b1, 32'h0,         1'b0, 1'b0, 32'h000, W0, 1'b1, 1'b1, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'h200, 1'b1, 32'hAAAAAAAA,  1'b1, 1'b0, 32'h200, W0, 1'b1, 1'b1, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h200, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'h000, W1, 1'b1, 1'b1, 32'h0,         32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h000, 1'b1, 32'h0,         1'b0, 1'b1, 32'h100, W0, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 32'h000, 1'b1, 32'h11111111,  1'b1, 1'b0, 32'h000, W0, 1'b1, 1'b1, 32'h11111111,  32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 32'h000, 1'b1, 32'h55555555,  1'b1, 1'b0, 32'h300, W1, 1'b1, 1'b1, 32'h0,         32'h55555555};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 32'h040, 1'b0, 32'h66666666,  1'b0, 1'b0, 32'h300, W0, 1'b0, 1'b0, 32'h66666666,  32'h0};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 32'h040, 1'b1, 32'h77777777,  1'b1, 1'b0, 32'h040, W0, 1'b1, 1'b1, 32'h77777777,  32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 32'h040, 1'b0, 32'h99999999,  1'b0, 1'b0, 32'h300, W0, 1'b1, 1'b1, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 32'h040, 1'b1, 32'h99999999,  1'b0, 1'b0, 32'h300, W0, 1'b1, 1'b1, 32'h0,         32'h0};

    // Directed table: single-master read, collision, slave stall, reset mid-transfer.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset        = vecs[i].rst;
      p0_bus.read  = vecs[i].p0_rd;
      p0_bus.write = vecs[i].p0_wr;
      p0_bus.addr  = vecs[i].p0_a;
      p1_bus.read  = vecs[i].p1_rd;
      p1_bus.addr  = vecs[i].p1_a;
      s_bus.ready  = vecs[i].sr;
      s_bus.rdata  = vecs[i].srd;
      #1;
      chk("vec_s_read",   i, 32'(s_bus.read),   32'(vecs[i].e_sread));
      chk("vec_s_write",  i, 32'(s_bus.write),  32'(vecs[i].e_swrite));
      chk("vec_s_addr",   i, s_bus.addr,        vecs[i].e_saddr);
      chk("vec_s_wdata",  i, s_bus.wdata,       vecs[i].e_swdata);
      chk("vec_p0_ready", i, 32'(p0_bus.ready), 32'(vecs[i].e_r0));
      chk("vec_p1_ready", i, 32'(p1_bus.ready), 32'(vecs[i].e_r1));
      chk("vec_p0_rdata", i, p0_bus.rdata,      vecs[i].e_d0);
      chk("vec_p1_rdata", i, p1_bus.rdata,      vecs[i].e_d1);
      $display("vec %0d: rst=%0b s_read=%0b s_write=%0b s_addr=%h rdy=%0b%0b rdata0=%h rdata1=%h",
               i, reset, s_bus.read, s_bus.write, s_bus.addr, p0_bus.ready, p1_bus.ready,
               p0_bus.rdata, p1_bus.rdata);
    end

    // Starvation: p0 reads every cycle while p1 holds a read to 0x400.
    begin
      int n_cyc;
      int p1_accepts;
      bit exp_win;
      n_cyc = GUARD ? 12 : 50;
      p1_accepts = 0;
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      p0_bus.read = 1'b1; p0_bus.addr = 32'h1000;
      p1_bus.read = 1'b1; p1_bus.addr = 32'h400;
      for (int k = 1; k <= n_cyc; k++) begin
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_win = GUARD && ((k % (MAX_WAIT + 1)) == 0);
        chk("starve_p1_ready", k, 32'(p1_bus.ready), 32'(exp_win));
        chk("starve_s_addr",   k, s_bus.addr, exp_win ? 32'h400 : 32'h1000);
        chk("starve_p0_ready", k, 32'(p0_bus.ready), 32'd1);
        if (p1_bus.ready) p1_accepts++;
        $display("starve %0d: s_addr=%h p1_ready=%0b", k, s_bus.addr, p1_bus.ready);
      end
      chk("starve_p1_accepts", 0, 32'(p1_accepts), GUARD ? 32'(n_cyc / (MAX_WAIT + 1)) : 32'd0);
    end

    // Randomized traffic against the reference model.
    m_owner = 0; m_wait = 0;
    p0_pend = 1'b0; p1_pend = 1'b0; p0_isw = 1'b0; p1_isw = 1'b0;
    p0_a = '0; p1_a = '0; p0_sz = 3'd2; p1_sz = 3'd2;
    for (int c = 0; c < NRAND; c++) begin
      int own;
      int win;
      bit ap;
      bit starving;
      bit e_rdy0, e_rdy1;
      @(negedge clk);
      reset = (c == 0) || ($urandom_range(0, 99) == 0);
      if (!p0_pend && ($urandom_range(0, 2) != 0)) begin
        p0_pend = 1'b1; p0_isw = 1'($urandom_range(0, 1)); p0_a = $urandom; p0_sz = 3'($urandom_range(0, 2));
      end
      if (!p1_pend && ($urandom_range(0, 1) != 0)) begin
        p1_pend = 1'b1; p1_isw = 1'($urandom_range(0, 1)); p1_a = $urandom; p1_sz = 3'($urandom_range(0, 2));
      end
      p0_wd = $urandom; p1_wd = $urandom; srd = $urandom;
      sr    = (m_owner == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      sresp = ($urandom_range(0, 7) == 0);
      p0_bus.read = p0_pend && !p0_isw; p0_bus.write = p0_pend && p0_isw;
      p0_bus.addr = p0_a; p0_bus.size = p0_sz; p0_bus.wdata = p0_wd;
      p1_bus.read = p1_pend && !p1_isw; p1_bus.write = p1_pend && p1_isw;
      p1_bus.addr = p1_a; p1_bus.size = p1_sz; p1_bus.wdata = p1_wd;
      s_bus.ready = sr; s_bus.rdata = srd; s_bus.resp = sresp;
      #1;

      own      = reset ? 0 : m_owner;
      ap       = !reset && ((own == 0) || sr);
      starving = GUARD && (m_wait >= MAX_WAIT);
      win      = 0;
      if (ap) begin
        if (p1_pend && (starving || !p0_pend)) win = 2;
        else if (p0_pend)                      win = 1;
      end
      e_rdy0 = reset ? 1'b1 : (own == 1) ? sr : (!p0_pend ? 1'b1 : (win == 1) && sr);
      e_rdy1 = reset ? 1'b1 : (own == 2) ? sr : (!p1_pend ? 1'b1 : (win == 2) && sr);

      chk("rnd_s_read",   c, 32'(s_bus.read),  32'(((win == 1) && !p0_isw) || ((win == 2) && !p1_isw)));
      chk("rnd_s_write",  c, 32'(s_bus.write), 32'(((win == 1) && p0_isw) || ((win == 2) && p1_isw)));
      if (win != 0) begin
        chk("rnd_s_addr", c, s_bus.addr,      (win == 2) ? p1_a : p0_a);
        chk("rnd_s_size", c, 32'(s_bus.size), 32'((win == 2) ? p1_sz : p0_sz));
      end
      chk("rnd_s_wdata",  c, s_bus.wdata,       (own == 2) ? p1_wd : p0_wd);
      chk("rnd_p0_ready", c, 32'(p0_bus.ready), 32'(e_rdy0));
      chk("rnd_p1_ready", c, 32'(p1_bus.ready), 32'(e_rdy1));
      chk("rnd_p0_rdata", c, p0_bus.rdata,      (own == 1) ? srd : 32'h0);
      chk("rnd_p1_rdata", c, p1_bus.rdata,      (own == 2) ? srd : 32'h0);
      chk("rnd_p0_resp",  c, 32'(p0_bus.resp),  (own == 1) ? 32'(sresp) : 32'(HASTI_RESP_OKAY));
      chk("rnd_p1_resp",  c, 32'(p1_bus.resp),  (own == 2) ? 32'(sresp) : 32'(HASTI_RESP_OKAY));

      if (reset) begin
        m_owner = 0;
        m_wait  = 0;
      end else begin
        if (!p1_pend || ((win == 2) && sr)) m_wait = 0;
        else if (ap && (win != 2) && (m_wait < MAX_WAIT)) m_wait++;
        if (ap && sr) begin
          m_owner = win;
          if (win != 0) begin
            $display("txn %0d: p%0d %s addr=%h", c, win - 1,
                     ((win == 1) ? p0_isw : p1_isw) ? "write" : "read ",
                     (win == 1) ? p0_a : p1_a);
          end
          if (win == 1) p0_pend = 1'b0;
          if (win == 2) p1_pend = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_arbiter.md
# vscale_hasti_arbiter

Two-master to one-slave arbiter for the simplified HASTI memory interface. It lets the core's dmem port (p0) and imem port (p1) share one single-ported HASTI SRAM in place of the dual-port SRAM. Each master keeps HASTI address/data-phase semantics, and the arbiter adds no latency. Arbitration is fixed-priority (p0 over p1), with an optional starvation guard for p1.

## Interface
- `MAX_WAIT`, default 4: consecutive lost arbitrations after which p1 is forced to win (guard only). Legal range 1–15.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `p0_addr`/`p1_addr` in `HASTI_ADDR_WIDTH`: address-phase address.
- `p0_read`/`p1_read`, `p0_write`/`p1_write` in 1: address-phase request type. Read and write are never both high on one port.
- `p0_size`/`p1_size` in `HASTI_SIZE_WIDTH`: transfer size.
- `p0_wdata`/`p1_wdata` in `HASTI_BUS_WIDTH`: data-phase write data.
- `p0_rdata`/`p1_rdata` out `HASTI_BUS_WIDTH`: data-phase read data.
- `p0_ready`/`p1_ready` out 1: per-master ready.
- `p0_resp`/`p1_resp` out `HASTI_RESP_WIDTH`: per-master response.
- `s_addr`, `s_read`, `s_write`, `s_size`, `s_wdata` out: forwarded to the slave.
- `s_rdata`, `s_ready`, `s_resp` in: from the slave.

## Operation
- **Request:** a master requests when `read|write` is high. It holds `addr`/`read`/`write`/`size` stable until its address phase is accepted.
- **Arbitration point:** any cycle where no data phase is outstanding, or the outstanding data phase completes (`s_ready`=1).
- **Arbitration rule:** p0 wins if it requests, unless the guard forces p1. Otherwise p1 wins if it requests. The winner's address fields are muxed combinationally onto `s_*`.
- **No winner:** `s_read`=`s_write`=0. `s_addr`, `s_size` and `s_wdata` are don't-care but driven from p0.
- **Acceptance:** the winner's address phase is accepted on the edge where `s_ready`=1. The registered data-phase owner `dp_owner` ∈ {NONE, P0, P1} becomes the winner.
- **Data phase:** `s_wdata` is muxed from `dp_owner`. `s_rdata`/`s_resp` go to the owner. The non-owner's rdata is 0 and its resp is OKAY.
- **Per-master ready:**
  - Owner of a data phase: `pX_ready` = `s_ready`.
  - Requesting loser at an arbitration point, or requesting while the other master holds the data phase without completing: `pX_ready`=0 (address phase extended).
  - Otherwise, including idle: `pX_ready`=1.
- **Pipelining:** a new address phase from either master may be accepted in the same cycle the previous data phase completes.
- **Simultaneous requests:** p0 wins; p1's `ready` stays 0 and its request is held.
- **Slave stall (`s_ready`=0) during a data phase:** no new acceptance; both masters see `ready`=0 if requesting.

## Timing
- Zero added latency. Address, wdata and rdata paths are combinational muxes; only `dp_owner` and the wait counter are registered.
- A read accepted at edge N returns `rdata` in cycle N+1 if `s_ready`=1, the same as a direct SRAM connection.
- **Reset values:** `dp_owner`=NONE, wait counter=0.
  - Outputs during and after reset: `s_read`=`s_write`=0, both `pX_ready`=1, `pX_resp`=OKAY, `pX_rdata`=0.
- **Reset mid-transfer:** the outstanding data phase is abandoned and no rdata is forwarded. The first post-reset cycle is an arbitration point.

## Configuration
- `VSCALE_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments each arbitration point where p1 requests and loses.
  - It clears when p1 is accepted or stops requesting, and saturates at `MAX_WAIT`.
  - At `MAX_WAIT`, p1 wins the next arbitration point even if p0 requests.
- Not defined: pure fixed priority. The counter is absent and p1 can starve indefinitely.

## Structure
- `dp_owner` encodings (NONE=0, P0=1, P1=2) go in `vscale_hasti_constants.vh` beside the existing HASTI widths and resp codes.
- One sub-module, `vscale_arb_starve_ctr` (counter plus force flag), is instantiated only under `VSCALE_ARB_STARVE_GUARD_EN`.
- The arbiter is instantiated in the sim top between `vscale_core` and a single-port `vscale_hasti_sram`.

## Test plan
- **Single-master reads:** p1 reads 0x200, slave returns 0xDEADBEEF.
  - Required: `s_read`=1 with `s_addr`=0x200 in the same cycle.
  - Required: `p1_rdata`=0xDEADBEEF with `p1_ready`=1 the next cycle, zero extra latency.
- **Collision:** p0 write 0x100 ← 0x12345678 and p1 read 0x000 in the same cycle.
  - Required: p0 accepted first and `p1_ready`=0.
  - Required: p1 accepted in the cycle p0's data phase completes.
  - Required: memory[0x100]=0x12345678.
- **Slave stall:** `s_ready`=0 for 3 cycles during a p0 read data phase.
  - Required: `p0_ready`=0 for those 3 cycles.
  - Required: a requesting p1 stays at `ready`=0 and no new `s_read` is accepted.
- **Starvation guard on:** p0 requests every cycle with `MAX_WAIT`=4.
  - Required: p1 accepted at exactly the 5th arbitration point.
  - Required: counter returns to 0 after acceptance.
- **Guard off:** same stimulus.
  - Required: p1 never accepted over 50 cycles.
- **Reset mid-transfer:** `reset` asserted during a p1 data phase.
  - Required: the next cycle shows `dp_owner`=NONE, both `ready`=1, `s_read`=`s_write`=0.
  - Required: no stale rdata is delivered.
